// File: rtl/sort4_ctrl.sv
// rtl/sort4_ctrl.sv - four-element bubble sorter sharing one magnitude compare unit

// Unsigned magnitude compare unit producing greater/equal/less flags.
module mag_cmp #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             g,
  output logic             e,
  output logic             l
);
  assign g = (a > b);
  assign e = (a == b);
  assign l = (a < b);
endmodule

// Sequential sort controller: one compare per clock, fixed 7-clock latency.
module sort4_ctrl #(
  parameter int WIDTH = 3,
  parameter bit DESC  = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [4*WIDTH-1:0] din,
  output logic               busy,
  output logic               done,
  output logic [4*WIDTH-1:0] dout,
  output logic [2:0]         swaps,
  output logic               cmp_g,
  output logic               cmp_e,
  output logic               cmp_l
);

  typedef enum logic [1:0] {IDLE, SORT, FIN} state_t;

  state_t                  state_q, state_d;
  logic [3:0][WIDTH-1:0]   r_q, r_d;
  logic [1:0]              pass_q, pass_d;
  logic [1:0]              idx_q, idx_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [4*WIDTH-1:0]      dout_q, dout_d;
  logic [2:0]              swaps_q, swaps_d;

  logic [WIDTH-1:0]        op_a, op_b;
  logic [1:0]              idx_nxt;
  logic [1:0]              last_idx;
  logic                    swap_en;

  assign idx_nxt  = idx_q + 2'd1;
  // Each pass stops one slot earlier since the largest (or smallest) has bubbled out.
  assign last_idx = 2'd2 - pass_q;

  // Steer the adjacent register pair selected by idx into the shared compare unit.
  always_comb begin
    op_a = r_q[0];
    op_b = r_q[1];
    case (idx_q)
      2'd0:    begin op_a = r_q[0]; op_b = r_q[1]; end
      2'd1:    begin op_a = r_q[1]; op_b = r_q[2]; end
      default: begin op_a = r_q[2]; op_b = r_q[3]; end
    endcase
  end

  mag_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a (op_a),
    .b (op_b),
    .g (cmp_g),
    .e (cmp_e),
    .l (cmp_l)
  );

  // Equal operands never swap, which keeps the sort stable.
  assign swap_en = DESC ? cmp_l : cmp_g;

  // Next-state and datapath update for the IDLE -> SORT -> FIN schedule.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    pass_d  = pass_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    swaps_d = swaps_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          r_d     = din;
          pass_d  = 2'd0;
          idx_d   = 2'd0;
          cnt_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = SORT;
        end
      end
      SORT: begin
        if (swap_en) begin
          r_d[idx_q]   = op_b;
          r_d[idx_nxt] = op_a;
          cnt_d        = cnt_q + 3'd1;
        end
        if (idx_q == last_idx) begin
          idx_d = 2'd0;
          if (pass_q == 2'd2) begin
            state_d = FIN;
          end else begin
            pass_d = pass_q + 2'd1;
          end
        end else begin
          idx_d = idx_nxt;
        end
      end
      FIN: begin
        dout_d  = r_q;
        swaps_d = cnt_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset discards any sort in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      pass_q  <= 2'd0;
      idx_q   <= 2'd0;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      swaps_q <= 3'd0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      pass_q  <= pass_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      swaps_q <= swaps_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign dout  = dout_q;
  assign swaps = swaps_q;

endmodule
